// File: rtl/delay_pkg.sv
// Types and constants shared by the delay datapath and its ADC/DAC/RAM front ends.
package delay_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StShift,
        StDone
    } adc_state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: while enabled, produces sck with SCK_DIV clk cycles per
// half-period, starting low, plus single-cycle pulses on the edges that flip sck.
module spi_sck_gen #(
    parameter int unsigned SCK_DIV = 2
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_pulse_o,
    output logic fall_pulse_o,
    output logic period_done_o
);

    localparam int unsigned DivW = $clog2(SCK_DIV + 1);
    localparam logic [DivW-1:0] DivLoad = DivW'(SCK_DIV);

    logic [DivW-1:0] div_q, div_d;
    logic            sck_q, sck_d;
    logic            tick;

    assign tick = en_i && (div_q == DivW'(1));

    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        if (!en_i) begin
            div_d = DivLoad;
            sck_d = 1'b0;
        end else if (tick) begin
            div_d = DivLoad;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q - DivW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o         = sck_q;
    assign rise_pulse_o  = tick && !sck_q;
    assign fall_pulse_o  = tick && sck_q;
    // A bit period ends when sck is driven back low.
    assign period_done_o = tick && sck_q;

endmodule

// File: rtl/adc_sampler.sv
// Serial ADC front end: strobes a conversion, clocks one sample in MSB-first over SPI
// and presents it in parallel with a one-cycle valid strobe.
module adc_sampler
    import delay_pkg::*;
#(
    parameter int unsigned DATA_W      = SAMPLE_W,
    parameter int unsigned CONV_CYCLES = 8,
    parameter int unsigned SCK_DIV     = 2,
    parameter bit          SIGNED_OUT  = 1'b1
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              start_i,
    input  logic              sdi_adc_i,
    output logic              cnv_adc_o,
    output logic              sck_adc_o,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    output logic              busy_o
);

    localparam int unsigned ConvW = $clog2(CONV_CYCLES + 1);
    localparam int unsigned BitW  = $clog2(DATA_W + 1);
    localparam logic [ConvW-1:0] ConvLoad = ConvW'(CONV_CYCLES);
    localparam logic [BitW-1:0]  BitLoad  = BitW'(DATA_W);
    // Flipping the MSB maps offset-binary ADC codes onto two's complement.
    localparam logic [DATA_W-1:0] SignMask =
        SIGNED_OUT ? {1'b1, {(DATA_W - 1){1'b0}}} : '0;

    adc_state_t        state_q, state_d;
    logic [ConvW-1:0]  conv_q, conv_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              cnv_q, cnv_d;
    logic              busy_q, busy_d;

    logic sck_en;
    logic sck;
    logic sck_rise;
    logic sck_fall;
    logic period_done;

    assign sck_en = (state_q == StShift);

    spi_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk_i         (clk_i),
        .nrst_i        (nrst_i),
        .en_i          (sck_en),
        .sck_o         (sck),
        .rise_pulse_o  (sck_rise),
        .fall_pulse_o  (sck_fall),
        .period_done_o (period_done)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StConv;
            StConv:  if (conv_q == ConvW'(1)) state_d = StShift;
            StShift: if (period_done && (bit_q == BitW'(1))) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        conv_d   = conv_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        cnv_d    = (state_d == StConv);
        busy_d   = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (start_i) conv_d = ConvLoad;
            end
            StConv: begin
                conv_d = conv_q - ConvW'(1);
                if (conv_q == ConvW'(1)) bit_d = BitLoad;
            end
            StShift: begin
                // Capture on the edge that raises sck; the ADC moves sdi on the falling edge.
                if (sck_rise) shreg_d = {shreg_q[DATA_W-2:0], sdi_adc_i};
                if (sck_fall) bit_d = bit_q - BitW'(1);
            end
            StDone: begin
                sample_d = shreg_q ^ SignMask;
                valid_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            conv_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            cnv_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            conv_q   <= conv_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            cnv_q    <= cnv_d;
            busy_q   <= busy_d;
        end
    end

    assign cnv_adc_o      = cnv_q;
    assign sck_adc_o      = sck;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: ADC models shift queued words out on falling sck and a
// scoreboard holds the expected sample, raw code and arrival edge of each conversion.
module tb_adc_sampler;

    localparam int Lat   = 73;   // 1 + 8 + 2*2*16
    localparam int LatS  = 18;   // 1 + 1 + 2*1*8
    localparam int Space = 74;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] r;
        logic [31:0] e;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    logic start, start_s;
    logic sdi, sdi_s;
    logic cnv, sck, valid, busy;
    logic cnv_r, sck_r, valid_r, busy_r;
    logic cnv_s, sck_s, valid_s, busy_s;
    logic [15:0] sample, sample_r;
    logic [7:0]  sample_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    exp_t sb_s[$];
    logic [15:0] mq[$];
    logic [7:0]  mq_s[$];
    logic [15:0] aw  = '0;
    logic [7:0]  aws = '0;

    always #5 clk = ~clk;

    assign sdi   = aw[15];
    assign sdi_s = aws[7];

    adc_sampler u_dut (
        .clk_i (clk), .nrst_i (nrst), .start_i (start), .sdi_adc_i (sdi),
        .cnv_adc_o (cnv), .sck_adc_o (sck), .sample_o (sample),
        .sample_valid_o (valid), .busy_o (busy)
    );

    adc_sampler #(.SIGNED_OUT (1'b0)) u_raw (
        .clk_i (clk), .nrst_i (nrst), .start_i (start), .sdi_adc_i (sdi),
        .cnv_adc_o (cnv_r), .sck_adc_o (sck_r), .sample_o (sample_r),
        .sample_valid_o (valid_r), .busy_o (busy_r)
    );

    adc_sampler #(.DATA_W (8), .CONV_CYCLES (1), .SCK_DIV (1), .SIGNED_OUT (1'b0)) u_small (
        .clk_i (clk), .nrst_i (nrst), .start_i (start_s), .sdi_adc_i (sdi_s),
        .cnv_adc_o (cnv_s), .sck_adc_o (sck_s), .sample_o (sample_s),
        .sample_valid_o (valid_s), .busy_o (busy_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pulse_start(input logic [15:0] w);
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{s: w ^ 16'h8000, r: w, e: 32'(cyc + 1 + Lat)});
        mq.push_back(w);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_ignored();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start_s(input logic [7:0] w);
        @(negedge clk);
        start_s = 1'b1;
        sb_s.push_back('{s: {8'h00, w}, r: {8'h00, w}, e: 32'(cyc + 1 + LatS)});
        mq_s.push_back(w);
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic monitor_loop();
        int   cnv_cnt = 0, rise_cnt = 0, busy_cnt = 0;
        int   cnv_cnt_s = 0, rise_cnt_s = 0, busy_cnt_s = 0;
        logic cnv_p = 0, sck_p = 0, valid_p = 0;
        logic cnv_sp = 0, sck_sp = 0, valid_sp = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!nrst) begin
                sb.delete();
                sb_s.delete();
                cnv_cnt = 0; rise_cnt = 0; busy_cnt = 0;
                cnv_cnt_s = 0; rise_cnt_s = 0; busy_cnt_s = 0;
                aw = '0;
                aws = '0;
            end else begin
                // ADC models: load a word when cnv rises, shift after sck falls.
                if (cnv && !cnv_p) aw = (mq.size() > 0) ? mq.pop_front() : 16'h0;
                if (!sck && sck_p) aw = {aw[14:0], 1'b0};
                if (cnv_s && !cnv_sp) aws = (mq_s.size() > 0) ? mq_s.pop_front() : 8'h0;
                if (!sck_s && sck_sp) aws = {aws[6:0], 1'b0};

                cnv_cnt  += int'(cnv);
                busy_cnt += int'(busy);
                if (sck && !sck_p) rise_cnt++;
                cnv_cnt_s  += int'(cnv_s);
                busy_cnt_s += int'(busy_s);
                if (sck_s && !sck_sp) rise_cnt_s++;

                if (valid) begin
                    check_eq("valid_back_to_back", 32'(valid_p), 0);
                    check_eq("valid_expected", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_eq("sample", 32'(sample), 32'(e.s));
                        check_eq("sample_raw", 32'(sample_r), 32'(e.r));
                        check_eq("valid_raw", 32'(valid_r), 1);
                        check_eq("latency", 32'(cyc), e.e);
                        check_eq("busy_at_valid", 32'(busy), 0);
                        check_eq("cnv_cycles", 32'(cnv_cnt), 8);
                        check_eq("sck_rises", 32'(rise_cnt), 16);
                        check_eq("busy_cycles", 32'(busy_cnt), 32'(Lat));
                    end
                    cnv_cnt = 0; rise_cnt = 0; busy_cnt = 0;
                end
                if (valid_s) begin
                    check_eq("s_valid_back_to_back", 32'(valid_sp), 0);
                    check_eq("s_valid_expected", 32'(sb_s.size() > 0), 1);
                    if (sb_s.size() > 0) begin
                        e = sb_s.pop_front();
                        check_eq("s_sample", 32'(sample_s), 32'(e.s));
                        check_eq("s_latency", 32'(cyc), e.e);
                        check_eq("s_cnv_cycles", 32'(cnv_cnt_s), 1);
                        check_eq("s_sck_rises", 32'(rise_cnt_s), 8);
                        check_eq("s_busy_cycles", 32'(busy_cnt_s), 32'(LatS));
                    end
                    cnv_cnt_s = 0; rise_cnt_s = 0; busy_cnt_s = 0;
                end
            end
            cnv_p  = cnv;   sck_p  = sck;   valid_p  = valid;
            cnv_sp = cnv_s; sck_sp = sck_s; valid_sp = valid_s;
        end
    endtask

    initial begin
        int k;
        nrst    = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check_eq("rst_cnv", 32'(cnv), 0);
        check_eq("rst_sck", 32'(sck), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_sample", 32'(sample), 0);
        check_eq("rst_valid", 32'(valid), 0);
        nrst = 1'b1;

        // All-ones input, then a mixed pattern.
        pulse_start(16'hFFFF);
        repeat (80) @(negedge clk);
        pulse_start(16'hA5C3);
        repeat (80) @(negedge clk);

        // Starts during CONV and SHIFT must be dropped.
        pulse_start(16'h1234);
        repeat (3) @(negedge clk);
        pulse_ignored();
        repeat (30) @(negedge clk);
        pulse_ignored();
        repeat (80) @(negedge clk);

        // start held high: accepted every Space cycles.
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            logic [15:0] w;
            w = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
            sb.push_back('{s: w ^ 16'h8000, r: w, e: 32'(k + Space * i + Lat)});
            mq.push_back(w);
        end
        repeat (300) @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);

        // Reset in the middle of bit 7 of the shift phase.
        pulse_start(16'hBEEF);
        repeat (36) @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_eq("arst_cnv", 32'(cnv), 0);
        check_eq("arst_sck", 32'(sck), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_sample", 32'(sample), 0);
        check_eq("arst_valid", 32'(valid), 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (80) @(negedge clk);
        pulse_start(16'h0F0F);
        repeat (80) @(negedge clk);

        // Smallest configuration: sck toggles every cycle.
        pulse_start_s(8'hA5);
        repeat (25) @(negedge clk);
        pulse_start_s(8'h3C);
        repeat (25) @(negedge clk);

        check_eq("sb_drained", 32'(sb.size()), 0);
        check_eq("sb_s_drained", 32'(sb_s.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
